// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit CPU sequencer.
//   - opcode encodings (OP_NOP .. OP_HALT)
//   - instruction field bit positions
//   - 3-bit FSM state encoding
//   - small opcode classification helpers
package cpu_pkg;

  // Opcode encodings
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Instruction field bit positions
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RA_MSB  = 8;
  localparam int RA_LSB  = 6;
  localparam int RB_MSB  = 5;
  localparam int RB_LSB  = 3;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Ops that update the Z flag (two-operand ALU ops)
  function automatic logic op_is_alu(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

  // Ops that produce a register result (ALU ops, LDI, MOV)
  function automatic logic op_is_writer(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_MOV);
  endfunction

  // Unassigned opcodes A..E
  function automatic logic op_is_illegal(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/cpu_ctrl_alu8.sv
// alu8: combinational 8-bit ALU for the CPU sequencer.
// Ports:
//   a, b   in  8 : operands (b carries imm8 for LDI)
//   op     in  4 : opcode
//   result out 8 : modulo-256 result, carry/borrow discarded
//   zero   out 1 : result == 8'h00
module alu8
  import cpu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] op,
  output logic [7:0] result,
  output logic       zero
);

  // Result select; LDI passes b (the immediate), MOV passes a
  always_comb begin
    result = 8'h00;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_LDI:  result = b;
      OP_MOV:  result = a;
      default: result = 8'h00;
    endcase
  end

  assign zero = (result == 8'h00);

endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle fetch/decode/execute/writeback sequencer.
// Ports:
//   clk_i, rst_i                 : clock, async active-high reset
//   imem_req_o/addr_o/ack_i/data_i: instruction fetch handshake
//   rd_addr_a_o/rd_addr_b_o      : register file read addresses (from ir)
//   rd_en_o, rd_a_i, rd_b_i      : operand consume strobe and read data
//   wr_en_o/wr_addr_o/wr_data_o  : register file write port (WB only)
//   halted_o                     : HALT executed
//   illegal_o                    : sticky, illegal opcode seen
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [7:0]  imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [15:0] imem_data_i,
  output logic [2:0]  rd_addr_a_o,
  output logic [2:0]  rd_addr_b_o,
  output logic        rd_en_o,
  input  logic [7:0]  rd_a_i,
  input  logic [7:0]  rd_b_i,
  output logic        wr_en_o,
  output logic [2:0]  wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic        halted_o,
  output logic        illegal_o
);

  state_t      state_r;
  logic [7:0]  pc_r;
  logic [15:0] ir_r;
  logic        z_r;

  logic [3:0]  op_s;
  logic [2:0]  rd_s;
  logic [7:0]  imm_s;
  logic [7:0]  alu_b_s;
  logic [7:0]  alu_res_s;
  logic        alu_zero_s;

  assign op_s  = ir_r[OP_MSB:OP_LSB];
  assign rd_s  = ir_r[RD_MSB:RD_LSB];
  assign imm_s = ir_r[IMM_MSB:IMM_LSB];

  // Read addresses come straight from the ir register, so they are stable
  // from DECODE through WB and zero after reset.
  assign rd_addr_a_o = ir_r[RA_MSB:RA_LSB];
  assign rd_addr_b_o = ir_r[RB_MSB:RB_LSB];

  // LDI routes its immediate through the b operand
  assign alu_b_s = (op_s == OP_LDI) ? imm_s : rd_b_i;

  alu8 u_alu (
    .a      (rd_a_i),
    .b      (alu_b_s),
    .op     (op_s),
    .result (alu_res_s),
    .zero   (alu_zero_s)
  );

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_FETCH;
      pc_r        <= RESET_PC;
      ir_r        <= 16'h0000;
      z_r         <= 1'b0;
      imem_req_o  <= 1'b0;
      imem_addr_o <= 8'h00;
      rd_en_o     <= 1'b0;
      wr_en_o     <= 1'b0;
      wr_addr_o   <= 3'd0;
      wr_data_o   <= 8'h00;
      halted_o    <= 1'b0;
      illegal_o   <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          // Only the first FETCH after reset arrives with req low; raise it here.
          if (!imem_req_o) begin
            imem_req_o  <= 1'b1;
            imem_addr_o <= pc_r;
          end else if (imem_ack_i) begin
            ir_r       <= imem_data_i;
            pc_r       <= pc_r + 8'd1;
            imem_req_o <= 1'b0;
            state_r    <= ST_DECODE;
          end else begin
            imem_req_o <= 1'b1;
          end
        end

        ST_DECODE: begin
          rd_en_o <= 1'b1;
          state_r <= ST_EXEC;
        end

        ST_EXEC: begin
          rd_en_o <= 1'b0;
          if (op_is_alu(op_s)) begin
            z_r <= alu_zero_s;
          end else begin
            z_r <= z_r;
          end
          if (op_is_writer(op_s) && (rd_s != 3'd0)) begin
            wr_en_o   <= 1'b1;
            wr_addr_o <= rd_s;
            wr_data_o <= alu_res_s;
            state_r   <= ST_WB;
          end else if ((op_s == OP_JMP) || ((op_s == OP_BZ) && z_r)) begin
            pc_r        <= imm_s;
            imem_req_o  <= 1'b1;
            imem_addr_o <= imm_s;
            state_r     <= ST_FETCH;
          end else if (op_s == OP_HALT) begin
            halted_o <= 1'b1;
            state_r  <= ST_HALT;
          end else begin
            // NOP, untaken BZ, writes to r0 and illegal opcodes
            if (op_is_illegal(op_s)) begin
              illegal_o <= 1'b1;
            end else begin
              illegal_o <= illegal_o;
            end
            imem_req_o  <= 1'b1;
            imem_addr_o <= pc_r;
            state_r     <= ST_FETCH;
          end
        end

        ST_WB: begin
          wr_en_o     <= 1'b0;
          wr_addr_o   <= 3'd0;
          wr_data_o   <= 8'h00;
          imem_req_o  <= 1'b1;
          imem_addr_o <= pc_r;
          state_r     <= ST_FETCH;
        end

        ST_HALT: begin
          halted_o   <= 1'b1;
          imem_req_o <= 1'b0;
          state_r    <= ST_HALT;
        end

        default: begin
          imem_req_o <= 1'b0;
          rd_en_o    <= 1'b0;
          wr_en_o    <= 1'b0;
          state_r    <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic [7:0]  imem_addr_o;
  logic        imem_ack_i;
  logic [15:0] imem_data_i;
  logic [2:0]  rd_addr_a_o;
  logic [2:0]  rd_addr_b_o;
  logic        rd_en_o;
  logic [7:0]  rd_a_i;
  logic [7:0]  rd_b_i;
  logic        wr_en_o;
  logic [2:0]  wr_addr_o;
  logic [7:0]  wr_data_o;
  logic        halted_o;
  logic        illegal_o;

  logic [15:0] mem [0:255];
  logic [7:0]  regs [0:7] = '{default: 8'h00};
  logic        ack_en;
  int          cyc = 0;
  int          wr_count = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          last_fetch_cyc = 0;
  int          last_wr_cyc = 0;

  always #5 clk = ~clk;

  cpu_ctrl #(.RESET_PC(8'h00)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .imem_req_o  (imem_req_o),
    .imem_addr_o (imem_addr_o),
    .imem_ack_i  (imem_ack_i),
    .imem_data_i (imem_data_i),
    .rd_addr_a_o (rd_addr_a_o),
    .rd_addr_b_o (rd_addr_b_o),
    .rd_en_o     (rd_en_o),
    .rd_a_i      (rd_a_i),
    .rd_b_i      (rd_b_i),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .halted_o    (halted_o),
    .illegal_o   (illegal_o)
  );

  // Zero-wait instruction memory and combinational-read register file
  assign imem_ack_i  = imem_req_o & ack_en;
  assign imem_data_i = mem[imem_addr_o];
  assign rd_a_i      = regs[rd_addr_a_o];
  assign rd_b_i      = regs[rd_addr_b_o];

  always @(posedge clk) cyc <= cyc + 1;

  // Register file commits on the falling edge
  always @(negedge clk) begin
    if (wr_en_o === 1'b1) begin
      regs[wr_addr_o] = wr_data_o;
      wr_count = wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for a fetch request, check its address, then step past the ack cycle
  task automatic wait_fetch(input logic [7:0] exp, input string tag);
    int n = 0;
    while (imem_req_o !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_req"}, {31'd0, imem_req_o}, 32'd1);
    check({tag, "_addr"}, {24'd0, imem_addr_o}, {24'd0, exp});
    last_fetch_cyc = cyc;
    @(posedge clk); #1;
  endtask

  // Wait for a write-back cycle, check address/data, then step past it
  task automatic wait_wr(input logic [2:0] ea, input logic [7:0] ed, input string tag);
    int n = 0;
    while (wr_en_o !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_wr"}, {21'd0, wr_en_o, wr_addr_o, wr_data_o}, {21'd0, 1'b1, ea, ed});
    last_wr_cyc = cyc;
    @(posedge clk); #1;
  endtask

  initial begin
    int fc, bc, jc, wc, bad, n;

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h6205;  // LDI r1,05
    mem[8'h01] = 16'h6403;  // LDI r2,03
    mem[8'h02] = 16'h1650;  // ADD r3,r1,r2
    mem[8'h03] = 16'h62FF;  // LDI r1,FF
    mem[8'h04] = 16'h6401;  // LDI r2,01
    mem[8'h05] = 16'h1650;  // ADD r3,r1,r2 -> 00
    mem[8'h06] = 16'h9020;  // BZ 20 (taken)
    mem[8'h20] = 16'h6203;  // LDI r1,03
    mem[8'h21] = 16'h6405;  // LDI r2,05
    mem[8'h22] = 16'h2650;  // SUB r3,r1,r2 -> FE
    mem[8'h23] = 16'h9040;  // BZ 40 (not taken)
    mem[8'h24] = 16'hB000;  // illegal
    mem[8'h25] = 16'h80FF;  // JMP FF
    mem[8'hFF] = 16'h0000;  // NOP

    ack_en = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl", {27'd0, imem_req_o, wr_en_o, rd_en_o, halted_o, illegal_o}, 32'd0);
    check("reset_addr", {imem_addr_o, 2'd0, rd_addr_a_o, rd_addr_b_o, wr_addr_o, wr_data_o},
          32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("req_after_reset", {23'd0, imem_req_o, imem_addr_o}, {23'd0, 1'b1, 8'h00});

    // LDI / LDI / ADD with latency
    wait_fetch(8'h00, "f00");
    wait_wr(3'd1, 8'h05, "ldi_r1");
    wait_fetch(8'h01, "f01");
    wait_wr(3'd2, 8'h03, "ldi_r2");
    wait_fetch(8'h02, "f02");
    fc = last_fetch_cyc;
    wait_wr(3'd3, 8'h08, "add_r3");
    check("add_wb_lat", last_wr_cyc - fc, 32'd3);
    wait_fetch(8'h03, "f03");
    check("add_total_lat", last_fetch_cyc - fc, 32'd4);
    check("regs_123", {8'd0, regs[1], regs[2], regs[3]}, {8'd0, 8'h05, 8'h03, 8'h08});

    // Overflow to zero, taken branch
    wait_wr(3'd1, 8'hFF, "ldi_ff");
    wait_fetch(8'h04, "f04");
    wait_wr(3'd2, 8'h01, "ldi_01");
    wait_fetch(8'h05, "f05");
    wait_wr(3'd3, 8'h00, "add_wrap");
    wait_fetch(8'h06, "f06");
    bc = last_fetch_cyc;
    wait_fetch(8'h20, "bz_taken");
    check("bz_lat", last_fetch_cyc - bc, 32'd3);

    // Borrow, untaken branch
    wait_wr(3'd1, 8'h03, "ldi_03");
    wait_fetch(8'h21, "f21");
    wait_wr(3'd2, 8'h05, "ldi_05");
    wait_fetch(8'h22, "f22");
    wait_wr(3'd3, 8'hFE, "sub_borrow");
    wait_fetch(8'h23, "f23");
    wait_fetch(8'h24, "bz_fall");

    // Illegal opcode
    wc = wr_count;
    check("illegal_pre", {31'd0, illegal_o}, 32'd0);
    wait_fetch(8'h25, "f25");
    check("illegal_set", {31'd0, illegal_o}, 32'd1);
    check("illegal_nowr", wr_count, wc);

    // JMP FF, NOP wraps to 00; then LDI r0 and HALT
    jc = last_fetch_cyc;
    mem[8'h00] = 16'h6055;  // LDI r0,55
    mem[8'h01] = 16'hF000;  // HALT
    wait_fetch(8'hFF, "jmp_ff");
    check("jmp_lat", last_fetch_cyc - jc, 32'd3);
    wait_fetch(8'h00, "pc_wrap");
    wc = wr_count;
    wait_fetch(8'h01, "f_halt");
    check("ldi_r0_nowr", wr_count, wc);
    repeat (2) @(posedge clk);
    #1;
    check("halted", {31'd0, halted_o}, 32'd1);
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (imem_req_o !== 1'b0 || halted_o !== 1'b1) bad++;
    end
    check("halt_hold", bad, 32'd0);
    check("illegal_sticky", {31'd0, illegal_o}, 32'd1);

    // Reset out of HALT, then reset in the middle of a WB
    mem[8'h00] = 16'h6A77;  // LDI r5,77
    rst = 1'b1;
    #1;
    check("rst_clears", {27'd0, halted_o, illegal_o, imem_req_o, wr_en_o, rd_en_o}, 32'd0);
    @(negedge clk); rst = 1'b0;
    n = 0;
    while (wr_en_o !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("wb_seen", {20'd0, wr_en_o, wr_addr_o, wr_data_o}, {20'd0, 1'b1, 3'd5, 8'h77});
    rst = 1'b1;
    #1;
    check("rst_in_wb", {imem_req_o, wr_en_o, rd_en_o, halted_o, illegal_o, wr_addr_o,
                        wr_data_o, imem_addr_o, 5'd0}, 32'd0);
    ack_en = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("restart_fetch", {23'd0, imem_req_o, imem_addr_o}, {23'd0, 1'b1, 8'h00});

    // Fetch stall: ack low for 5 cycles
    wc = wr_count;
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 8'h00) bad++;
    end
    check("stall_stable", bad, 32'd0);
    check("stall_nowr", wr_count, wc);
    ack_en = 1'b1;
    wait_wr(3'd5, 8'h77, "after_stall");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
